// File: rtl/gf233_pkg.sv
// Shared constants and FSM encodings for the GF(2^233) reduction stage.
// Field polynomial f(x) = x^233 + x^74 + 1; products arrive unreduced, 2*M-1 bits wide.
// State codes are plain localparams so older tooling and waveform viewers read them directly.
package gf233_pkg;

  localparam int M      = 233;
  localparam int TAP    = 74;
  localparam int PROD_W = 2*M - 1;
  localparam int HI_W   = PROD_W - M;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_FOLD = 2'd1;
  localparam state_t ST_HOLD = 2'd2;

endpackage

// File: rtl/gf233_fold.sv
// Purpose : one reduction fold, x^233 == x^74 + 1 applied to every coefficient above x^232.
// Latency : purely combinational, no state.
// Ports   : r_in  - PROD_W-bit polynomial, r_out - folded PROD_W-bit polynomial (same residue mod f).
module gf233_fold
  import gf233_pkg::*;
(
  input  logic [PROD_W-1:0] r_in,
  output logic [PROD_W-1:0] r_out
);

  logic [PROD_W-1:0] lo_ext;
  logic [PROD_W-1:0] h_ext;

  // h * x^233 becomes h * (x^74 + 1); h is at most 232 bits, so h << 74 tops out at x^305
  // and never spills past the register.
  assign lo_ext = {{HI_W{1'b0}}, r_in[M-1:0]};
  assign h_ext  = {{M{1'b0}}, r_in[PROD_W-1:M]};
  assign r_out  = lo_ext ^ h_ext ^ (h_ext << TAP);

endmodule

// File: rtl/gf233_reduce.sv
// Purpose : reduce a 465-bit carry-less product to its canonical GF(2^233) element by iterative folding.
// Latency : 2 cycles accept-to-out_valid; with GF233_REDUCE_EARLY_EXIT_EN defined, 1/2/3 cycles depending on degree.
// Backpres: single operand held; in_ready low from accept until the result is taken, y/out_valid hold while out_ready=0.
// Ports   : clk, rst (sync, active-high); in_valid/in_ready/c = product input; out_valid/out_ready/y = reduced output.
// Config  : `define GF233_REDUCE_EARLY_EXIT_EN to leave FOLD as soon as the upper half is already zero.
module gf233_reduce
  import gf233_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] c,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [M-1:0]      y
);

  state_t            state;
  logic [PROD_W-1:0] r;
  logic [PROD_W-1:0] r_fold;
  logic [1:0]        fold_cnt;

  gf233_fold u_fold (
    .r_in  (r),
    .r_out (r_fold)
  );

`ifdef GF233_REDUCE_EARLY_EXIT_EN
  logic hi_zero;
  assign hi_zero = (r[PROD_W-1:M] == '0);
`endif

  // in_ready is gated by rst so the input side looks busy for the whole reset window.
  assign in_ready  = (state == ST_IDLE) && !rst;
  assign out_valid = (state == ST_HOLD);
  // y is forced to zero outside HOLD so a stale residue from a discarded operation never shows.
  assign y         = out_valid ? r[M-1:0] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      r        <= '0;
      fold_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            r        <= c;
            fold_cnt <= '0;
            state    <= ST_FOLD;
          end
        end
        ST_FOLD: begin
`ifdef GF233_REDUCE_EARLY_EXIT_EN
          // Exit only on an observed-clean upper half; after two folds it is guaranteed clean,
          // so the worst case costs one extra detect cycle.
          if (hi_zero) begin
            state <= ST_HOLD;
          end else begin
            r        <= r_fold;
            fold_cnt <= fold_cnt + 2'd1;
          end
`else
          // Fixed two folds: a fold of an already-reduced value is a no-op, so latency stays constant.
          r        <= r_fold;
          fold_cnt <= fold_cnt + 2'd1;
          if (fold_cnt == 2'd1) begin
            state <= ST_HOLD;
          end
`endif
        end
        ST_HOLD: begin
          if (out_ready) begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
